// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       retire;
    logic       halted;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src,
               retire, halted, state
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src,
               retire, halted, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control FSM: sequences fetch/decode/execute over a
// shared memory port, watches the memory handshake for timeouts and halts on
// illegal opcodes (optionally) or a stalled memory.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX    = 15,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC_R = 4'd6,  EXEC_I = 4'd7,
        ALUWB  = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, LUI    = 4'd11,
        HALT   = 4'd15
    } state_t;

    state_t     st, st_nx;
    logic [7:0] wcnt, wcnt_nx;
    logic       mem_st, tmo;

    // Waiting states share one counter; it restarts whenever a wait ends.
    assign mem_st  = (st == FETCH) || (st == MEMRD) || (st == MEMWR);
    assign tmo     = mem_st && !bus.mem_ready && (wcnt == 8'(MEM_WAIT_MAX));
    assign wcnt_nx = (mem_st && !bus.mem_ready) ? wcnt + 8'd1 : 8'd0;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= FETCH;
            wcnt <= 8'd0;
        end else begin
            st   <= st_nx;
            wcnt <= wcnt_nx;
        end
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        bus.imm_src = 3'b000;
        case (bus.opcode)
            OP_STORE:  bus.imm_src = 3'b001;
            OP_BRANCH: bus.imm_src = 3'b010;
            OP_JAL:    bus.imm_src = 3'b011;
            OP_LUI:    bus.imm_src = 3'b100;
            default:   bus.imm_src = 3'b000;
        endcase
    end

    // Next-state and control decode; a memory ready in the limit cycle wins over timeout.
    always_comb begin
        st_nx          = st;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.result_src = 2'b00;
        bus.retire     = 1'b0;
        bus.halted     = 1'b0;
        case (st)
            FETCH: begin
                bus.mem_req    = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    st_nx        = DECODE;
                end else if (tmo) begin
                    st_nx = HALT;
                end
            end
            DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: st_nx = MEMADR;
                    OP_R:              st_nx = EXEC_R;
                    OP_I:              st_nx = EXEC_I;
                    OP_BRANCH:         st_nx = BRANCH;
                    OP_JAL:            st_nx = JAL;
                    OP_LUI:            st_nx = LUI;
                    default: begin
                        if (HALT_ON_ILLEGAL) begin
                            st_nx = HALT;
                        end else begin
                            bus.retire = 1'b1;
                            st_nx      = FETCH;
                        end
                    end
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                st_nx         = (bus.opcode == OP_STORE) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
                if (bus.mem_ready) st_nx = MEMWB;
                else if (tmo)      st_nx = HALT;
            end
            MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
                bus.retire     = 1'b1;
                st_nx          = FETCH;
            end
            MEMWR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.adr_src = 1'b1;
                if (bus.mem_ready) begin
                    bus.retire = 1'b1;
                    st_nx      = FETCH;
                end else if (tmo) begin
                    st_nx = HALT;
                end
            end
            EXEC_R: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b10;
                st_nx         = ALUWB;
            end
            EXEC_I: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 2'b10;
                st_nx         = ALUWB;
            end
            ALUWB: begin
                bus.reg_write = 1'b1;
                bus.retire    = 1'b1;
                st_nx         = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b01;
                // Only beq/bne are supported; other funct3 values fall through untaken.
                bus.pc_write  = ((bus.funct3 == 3'b000) &&  bus.zero) ||
                                ((bus.funct3 == 3'b001) && !bus.zero);
                bus.retire    = 1'b1;
                st_nx         = FETCH;
            end
            JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_write  = 1'b1;
                st_nx         = ALUWB;
            end
            LUI: begin
                bus.alu_src_a = 2'b11;
                bus.alu_src_b = 2'b01;
                st_nx         = ALUWB;
            end
            HALT: begin
                bus.halted = 1'b1;
            end
            default: st_nx = HALT;
        endcase
    end

    assign bus.state = st;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes expected retire/halt/
// snapshot events, a forked monitor pops and compares them at each negedge.
// Two instances run side by side: illegal opcodes halt (dut) or retire (dut2).
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef struct {
        int         kind;   // 0 retire, 1 halt entry, 2 snapshot
        int         gap;    // negedges since previous retire / reset
        logic [3:0] st;
        logic       rw, pw, irw, hlt, mreq;
        logic [2:0] imm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic snap_req;
    int   compared, mismatched, cyc;
    int   last [2];
    logic prevh [2];
    exp_t q1[$], q2[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
    multicycle_ctrl_if bus2 ();
    assign bus2.opcode    = bus.opcode;
    assign bus2.funct3    = bus.funct3;
    assign bus2.zero      = bus.zero;
    assign bus2.mem_ready = bus.mem_ready;

    multicycle_ctrl #(.MEM_WAIT_MAX(15), .HALT_ON_ILLEGAL(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
    multicycle_ctrl #(.MEM_WAIT_MAX(15), .HALT_ON_ILLEGAL(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Moore outputs per state, straight from the state table:
    // {mem_req, mem_we, adr_src, alu_src_a, alu_src_b, alu_op, result_src, halted}
    function automatic logic [11:0] moore_exp(input logic [3:0] s);
        case (s)
            4'd0:    return {1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
            4'd1:    return {1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
            4'd2:    return {1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
            4'd3:    return {1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            4'd4:    return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
            4'd5:    return {1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            4'd6:    return {1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
            4'd7:    return {1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
            4'd8:    return 12'h000;
            4'd9:    return {1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
            4'd10:   return {1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
            4'd11:   return {1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0};
            4'd15:   return 12'h001;
            default: return 12'hfff;
        endcase
    endfunction

    task automatic chk(input string nm, input int id, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s dut%0d @cyc %0d: got %0d, expected %0d", nm, id, cyc, act, exp);
        end
    endtask

    task automatic push(input int mask, input int kind, input int gap, input logic [3:0] st,
                        input logic rw, input logic pw, input logic irw, input logic hlt,
                        input logic mreq, input logic [2:0] imm);
        exp_t e;
        e.kind = kind; e.gap = gap; e.st = st; e.rw = rw; e.pw = pw;
        e.irw = irw; e.hlt = hlt; e.mreq = mreq; e.imm = imm;
        if (mask[0]) q1.push_back(e);
        if (mask[1]) q2.push_back(e);
    endtask

    // One DUT observation per negedge; mv packs the Moore outputs like moore_exp.
    task automatic mon(input int id, input logic [3:0] st, input logic rt, input logic rw,
                       input logic pw, input logic irw, input logic [2:0] imm, input logic [11:0] mv);
        exp_t e;
        int   evt;
        if (!rst) begin
            last[id]  = cyc;
            prevh[id] = 1'b0;
            return;
        end
        chk("moore_outputs", id, int'(mv), int'(moore_exp(st)));
        if (rw && !(st == 4'd4 || st == 4'd8)) chk("reg_write_state", id, int'(st), 8);
        evt = snap_req ? 2 : rt ? 0 : (mv[0] && !prevh[id]) ? 1 : -1;
        prevh[id] = mv[0];
        if (evt < 0) return;
        if ((id == 0 && q1.size() == 0) || (id == 1 && q2.size() == 0)) begin
            chk("unexpected_event", id, evt, -1);
            return;
        end
        if (id == 0) e = q1.pop_front();
        else         e = q2.pop_front();
        chk("event_kind", id, evt, e.kind);
        case (evt)
            0: begin
                chk("retire_gap", id, cyc - last[id], e.gap);
                chk("retire_state", id, int'(st), int'(e.st));
                chk("retire_reg_write", id, int'(rw), int'(e.rw));
                chk("retire_pc_write", id, int'(pw), int'(e.pw));
                chk("retire_imm_src", id, int'(imm), int'(e.imm));
                last[id] = cyc;
            end
            1: begin
                chk("halt_gap", id, cyc - last[id], e.gap);
                chk("halt_state", id, int'(st), int'(e.st));
                chk("halt_mem_req", id, int'(mv[11]), int'(e.mreq));
            end
            default: begin
                chk("snap_state", id, int'(st), int'(e.st));
                chk("snap_mem_req", id, int'(mv[11]), int'(e.mreq));
                chk("snap_ir_write", id, int'(irw), int'(e.irw));
                chk("snap_pc_write", id, int'(pw), int'(e.pw));
                chk("snap_halted", id, int'(mv[0]), int'(e.hlt));
            end
        endcase
    endtask

    task automatic timeout(input string nm);
        compared++;
        mismatched++;
        $display("FAIL timeout %s @cyc %0d: event not seen, expected within bound", nm, cyc);
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b0;
        bus.mem_ready = rdy;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_ret(input int lim);
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (bus.retire) break;
        end
        if (bus.retire !== 1'b1) timeout("retire");
    endtask

    task automatic wait_halt(input int lim);
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (bus.halted) break;
        end
        if (bus.halted !== 1'b1) timeout("halt");
    endtask

    task automatic wait_state(input logic [3:0] s, input int lim);
        for (int n = 0; n < lim; n++) begin
            @(posedge clk);
            #1;
            if (bus.state == s) break;
        end
        if (bus.state !== s) timeout("state");
    endtask

    // Issue one instruction (called inside its FETCH cycle) and run it to retire.
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic z, input int gap,
                       input logic [3:0] st, input logic rw, input logic pw, input logic [2:0] imm);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.zero   = z;
        push(3, 0, gap, st, rw, pw, 1'b0, 1'b0, 1'b0, imm);
        wait_ret(20);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; snap_req = 1'b0; compared = 0; mismatched = 0; cyc = 0;
        last[0] = 0; last[1] = 0; prevh[0] = 1'b0; prevh[1] = 1'b0;
        bus.opcode = OP_R; bus.funct3 = 3'b000; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        fork
            forever begin
                @(negedge clk);
                cyc++;
                mon(0, bus.state, bus.retire, bus.reg_write, bus.pc_write, bus.ir_write, bus.imm_src,
                    {bus.mem_req, bus.mem_we, bus.adr_src, bus.alu_src_a, bus.alu_src_b,
                     bus.alu_op, bus.result_src, bus.halted});
                mon(1, bus2.state, bus2.retire, bus2.reg_write, bus2.pc_write, bus2.ir_write, bus2.imm_src,
                    {bus2.mem_req, bus2.mem_we, bus2.adr_src, bus2.alu_src_a, bus2.alu_src_b,
                     bus2.alu_op, bus2.result_src, bus2.halted});
            end
        join_none

        // Reset state: FETCH, no ir_write until mem_ready, then a full instruction stream.
        do_reset(1'b0);
        push(3, 2, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        snap_req = 1'b1;
        @(posedge clk);
        #1;
        push(3, 2, 0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1 snap_req = 1'b0;
        // One wait cycle in the first FETCH stretches the R-type from 4 to 5.
        run(OP_R,      3'b000, 1'b0, 5, 4'd8, 1'b1, 1'b0, 3'b000);
        run(OP_LOAD,   3'b010, 1'b0, 5, 4'd4, 1'b1, 1'b0, 3'b000);
        run(OP_STORE,  3'b010, 1'b0, 4, 4'd5, 1'b0, 1'b0, 3'b001);
        run(OP_BRANCH, 3'b000, 1'b1, 3, 4'd9, 1'b0, 1'b1, 3'b010);
        run(OP_BRANCH, 3'b001, 1'b1, 3, 4'd9, 1'b0, 1'b0, 3'b010);
        run(OP_BRANCH, 3'b001, 1'b0, 3, 4'd9, 1'b0, 1'b1, 3'b010);
        run(OP_BRANCH, 3'b100, 1'b0, 3, 4'd9, 1'b0, 1'b0, 3'b010);
        run(OP_JAL,    3'b000, 1'b0, 4, 4'd8, 1'b1, 1'b0, 3'b011);
        run(OP_LUI,    3'b000, 1'b0, 4, 4'd8, 1'b1, 1'b0, 3'b100);
        run(OP_I,      3'b000, 1'b0, 4, 4'd8, 1'b1, 1'b0, 3'b000);

        // lw with three stall cycles in MEMRD: 5 + 3 = 8.
        bus.opcode = OP_LOAD;
        do_reset(1'b1);
        push(3, 0, 8, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        wait_state(4'd3, 10);
        bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.mem_ready = 1'b1;
        wait_ret(20);
        @(posedge clk);
        #1;

        // FETCH never served: 16 FETCH cycles then HALT, which survives mem_ready.
        bus.opcode = OP_R;
        do_reset(1'b0);
        push(3, 1, 17, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        wait_halt(40);
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push(3, 2, 0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        snap_req = 1'b1;
        @(posedge clk);
        #1 snap_req = 1'b0;

        // Illegal opcode: dut halts after DECODE, dut2 retires in DECODE with no write.
        bus.opcode = OP_BAD;
        do_reset(1'b1);
        push(1, 1, 3, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        push(2, 0, 2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        wait_halt(10);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("leftover_expectations", 0, q1.size(), 0);
        chk("leftover_expectations", 1, q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
